// File: rtl/hc153_scan_ctrl.sv
// ---------------------------------------------------------------------------
// hc153_scan_ctrl
//
// Sequencer wrapped around an HC153 4:1 multiplexer. It drives the mux select
// and active-low enable, steps through channels 0..3, waits SETTLE_CYCLES
// clocks on each channel and then samples the mux output. The four samples
// are presented as one parallel word together with a single-cycle done
// pulse, which turns the combinational mux into a scanned 4-input port.
//
// Parameters:
//   SETTLE_CYCLES  clocks held on each channel before sampling (1..255)
//   CNT_W          settle counter width, 2**CNT_W must exceed SETTLE_CYCLES
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   rst      synchronous active-high reset
//   start    request one 4-channel scan, honoured only while idle
//   cont     (HC153_SCAN_CONT_EN only) restart a new scan straight from DONE
//   mux_out  output bit of the HC153
//   sel      channel select to the HC153
//   ei       HC153 enable, active-low (0 = mux enabled)
//   busy     high from the cycle after start is accepted until DONE is left
//   done     one-cycle pulse, data is valid and freshly updated
//   data     captured word, data[k] = mux_out sampled while sel = k
//
// Build option:
//   HC153_SCAN_CONT_EN  adds the cont input for back-to-back scanning.
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module hc153_scan_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef HC153_SCAN_CONT_EN
    input  logic       cont,
`endif
    input  logic       mux_out,
    output logic [1:0] sel,
    output logic       ei,
    output logic       busy,
    output logic       done,
    output logic [3:0] data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_reg,  state_next;
    logic [1:0]       sel_reg,    sel_next;
    logic             ei_reg,     ei_next;
    logic             busy_reg,   busy_next;
    logic             done_reg,   done_next;
    logic [3:0]       data_reg,   data_next;
    logic [3:0]       shadow_reg, shadow_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;

    // When set in DONE, the next scan starts without passing through IDLE.
    logic rearm;
`ifdef HC153_SCAN_CONT_EN
    assign rearm = cont;
`else
    assign rearm = 1'b0;
`endif

    // Per-channel capture: a shadow bit only loads while its channel is the
    // one being sampled, otherwise it keeps the value from earlier in the scan.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_shadow
            assign shadow_next[gi] = (state_reg == S_SAMPLE && sel_reg == 2'(gi))
                                     ? mux_out : shadow_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            sel_reg    <= 2'd0;
            ei_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            data_reg   <= 4'd0;
            shadow_reg <= 4'd0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            ei_reg     <= ei_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            data_reg   <= data_next;
            shadow_reg <= shadow_next;
            cnt_reg    <= cnt_next;
        end
    end

    // Next-state logic also computes the next value of every registered
    // output, so each output reflects the state it is entering.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        ei_next    = ei_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        data_next  = data_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            S_IDLE: begin
                sel_next  = 2'd0;
                ei_next   = 1'b1;
                busy_next = 1'b0;
                if (start) begin
                    state_next = S_SETTLE;
                    ei_next    = 1'b0;
                    busy_next  = 1'b1;
                    cnt_next   = '0;
                end
            end

            S_SETTLE: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = S_SAMPLE;
                end
            end

            S_SAMPLE: begin
                if (sel_reg == 2'd3) begin
                    // Last channel: its bit bypasses the shadow so the full
                    // word lands in data on the same edge.
                    state_next = S_DONE;
                    data_next  = {mux_out, shadow_reg[2:0]};
                    done_next  = 1'b1;
                    ei_next    = 1'b1;
                    sel_next   = 2'd0;
                end else begin
                    state_next = S_SETTLE;
                    sel_next   = sel_reg + 2'd1;
                    cnt_next   = '0;
                end
            end

            S_DONE: begin
                sel_next = 2'd0;
                if (rearm) begin
                    state_next = S_SETTLE;
                    ei_next    = 1'b0;
                    busy_next  = 1'b1;
                    cnt_next   = '0;
                end else begin
                    state_next = S_IDLE;
                    ei_next    = 1'b1;
                    busy_next  = 1'b0;
                end
            end

            default: begin
                state_next = S_IDLE;
                sel_next   = 2'd0;
                ei_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign sel  = sel_reg;
    assign ei   = ei_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign data = data_reg;

endmodule
